// File: rtl/ycr_imem_sram_resp.sv
// Instruction-memory responder: turns imem read bursts into single-port SRAM reads
// with one response per beat, error replies for writes and out-of-window addresses.
module ycr_imem_sram_resp #(
  parameter int                 AWIDTH       = 32,
  parameter int                 DWIDTH       = 32,
  parameter int                 BSIZE        = 3,
  parameter int                 MEM_AW       = 10,
  parameter logic [AWIDTH-1:0]  BASE_MASK    = 'hFFFF_F000,
  parameter logic [AWIDTH-1:0]  BASE_PATTERN = 'h0001_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_req,
  input  logic              imem_cmd,
  input  logic [AWIDTH-1:0] imem_addr,
  input  logic [BSIZE-1:0]  imem_bl,
  output logic              imem_req_ack,
  output logic [DWIDTH-1:0] imem_rdata,
  output logic [1:0]        imem_resp,
  input  logic              mem_gnt,
  output logic              mem_cs,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_OK     = 2'b01;
  localparam logic [1:0] RESP_ER     = 2'b10;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [BSIZE-1:0]  beats_left_q, beats_left_d;
  logic              rd_pend_q, rd_pend_d;
  logic              err_pend_q, err_pend_d;

  logic              req_hit;
  logic              cur_hit;
  logic              can_accept;
  logic              accept;
  logic              accept_rd;
  logic              burst_open;
  logic              burst_issue;

  function automatic logic addr_hit(input logic [AWIDTH-1:0] a);
    return (a & BASE_MASK) == BASE_PATTERN;
  endfunction

  always_comb begin
    req_hit     = addr_hit(imem_addr);
    cur_hit     = addr_hit(cur_addr_q);
    can_accept  = ((state_q == ST_IDLE) && !rd_pend_q) ||
                  ((state_q == ST_RD) && rd_pend_q && (beats_left_q == '0));
    imem_req_ack = can_accept && mem_gnt && !rst;
    accept      = imem_req && imem_req_ack;
    accept_rd   = accept && !imem_cmd && req_hit;
    burst_open  = (state_q == ST_RD) && !err_pend_q && (beats_left_q != '0);
    burst_issue = burst_open && cur_hit && mem_gnt && !rst;
  end

  // SRAM strobe: a fresh accept uses the request address directly, so the
  // first beat costs no extra cycle.
  always_comb begin
    mem_cs   = accept_rd || burst_issue;
    mem_addr = '0;
    if (accept_rd) begin
      mem_addr = imem_addr[MEM_AW+1:2];
    end else if (burst_issue) begin
      mem_addr = cur_addr_q[MEM_AW+1:2];
    end
  end

  always_comb begin
    imem_resp  = RESP_NOTRDY;
    imem_rdata = '0;
    if (!rst) begin
      if (rd_pend_q) begin
        imem_resp  = RESP_OK;
        imem_rdata = mem_rdata;
      end else if ((state_q == ST_ERR) || err_pend_q) begin
        imem_resp = RESP_ER;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_pend_d    = rd_pend_q;
    err_pend_d   = err_pend_q;

    case (state_q)
      ST_IDLE: begin
        rd_pend_d = 1'b0;
      end
      ST_RD: begin
        if (err_pend_q) begin
          state_d      = ST_IDLE;
          cur_addr_d   = '0;
          beats_left_d = '0;
          rd_pend_d    = 1'b0;
          err_pend_d   = 1'b0;
        end else if (beats_left_q != '0) begin
          if (!cur_hit) begin
            // Burst walked out of the window: drop the rest, report once.
            err_pend_d   = 1'b1;
            beats_left_d = '0;
            rd_pend_d    = 1'b0;
          end else if (mem_gnt) begin
            beats_left_d = beats_left_q - 1'b1;
            cur_addr_d   = cur_addr_q + AWIDTH'(4);
            rd_pend_d    = 1'b1;
          end else begin
            rd_pend_d = 1'b0;
          end
        end else begin
          state_d    = ST_IDLE;
          cur_addr_d = '0;
          rd_pend_d  = 1'b0;
        end
      end
      ST_ERR: begin
        state_d      = ST_IDLE;
        cur_addr_d   = '0;
        beats_left_d = '0;
        rd_pend_d    = 1'b0;
        err_pend_d   = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        cur_addr_d   = '0;
        beats_left_d = '0;
        rd_pend_d    = 1'b0;
        err_pend_d   = 1'b0;
      end
    endcase

    // An accept overrides the end-of-burst return to idle (pipelined start).
    if (accept) begin
      err_pend_d = 1'b0;
      if (accept_rd) begin
        state_d      = ST_RD;
        rd_pend_d    = 1'b1;
        beats_left_d = (imem_bl == '0) ? '0 : imem_bl - 1'b1;
        cur_addr_d   = imem_addr + AWIDTH'(4);
      end else begin
        state_d      = ST_ERR;
        rd_pend_d    = 1'b0;
        beats_left_d = '0;
        cur_addr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_pend_q    <= 1'b0;
      err_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_pend_q    <= rd_pend_d;
      err_pend_q   <= err_pend_d;
    end
  end

endmodule

// File: tb/tb_ycr_imem_sram_resp.sv
// Bench for ycr_imem_sram_resp: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a beat-level behavioural model.
module tb_ycr_imem_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_cmd;
  logic [31:0] imem_addr;
  logic [2:0]  imem_bl;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        mem_gnt;
  logic        mem_cs;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;

  ycr_imem_sram_resp dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_cmd     (imem_cmd),
    .imem_addr    (imem_addr),
    .imem_bl      (imem_bl),
    .imem_req_ack (imem_req_ack),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .mem_gnt      (mem_gnt),
    .mem_cs       (mem_cs),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro: one-cycle read latency, garbage on cycles without a read.
  logic [31:0] sram [0:1023];
  always @(posedge clk) begin
    if (mem_cs) mem_rdata <= sram[mem_addr];
    else        mem_rdata <= $urandom;
  end

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'h3333_0002;
  localparam logic [31:0] D3 = 32'h4444_0003;
  localparam logic [31:0] E0 = 32'hCAFE_03FE;
  localparam logic [31:0] E1 = 32'hF00D_03FF;

  int nchecks = 0;
  int nerrors = 0;
  int ntxn    = 0;

  // Model: beats still to issue, next beat address, and the response due now.
  int          m_remaining;
  logic [31:0] m_next_addr;
  int          m_due;        // 0 none, 1 ok, 2 error
  logic [9:0]  m_due_word;

  logic        obs_ack, obs_cs;
  logic [9:0]  obs_maddr;
  logic [1:0]  obs_resp;
  logic [31:0] obs_rdata;

  function automatic bit in_win(input logic [31:0] a);
    return (a & 32'hFFFF_F000) == 32'h0001_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit req, input bit cmd, input logic [31:0] addr,
                       input logic [2:0] bl, input bit gnt);
    bit          e_ack, e_cs;
    logic [9:0]  e_maddr;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int          new_due;
    @(posedge clk);
    #1;
    rst = r; imem_req = req; imem_cmd = cmd; imem_addr = addr; imem_bl = bl; mem_gnt = gnt;
    @(negedge clk);

    e_ack   = !r && gnt && (m_remaining == 0) && (m_due != 2);
    e_cs    = 1'b0;
    e_maddr = '0;
    if (!r) begin
      if (e_ack && req) begin
        if (!cmd && in_win(addr)) begin
          e_cs = 1'b1; e_maddr = addr[11:2];
        end
      end else if (m_remaining > 0 && in_win(m_next_addr) && gnt) begin
        e_cs = 1'b1; e_maddr = m_next_addr[11:2];
      end
    end
    e_resp  = r ? 2'd0 : 2'(m_due);
    e_rdata = (!r && m_due == 1) ? sram[m_due_word] : 32'h0;

    obs_ack = imem_req_ack; obs_cs = mem_cs; obs_maddr = mem_addr;
    obs_resp = imem_resp; obs_rdata = imem_rdata;
    chk("req_ack", imem_req_ack, e_ack);
    chk("mem_cs", mem_cs, e_cs);
    chk("mem_addr", mem_addr, e_maddr);
    chk("resp", imem_resp, e_resp);
    chk("rdata", imem_rdata, e_rdata);

    if (r) begin
      m_remaining = 0; m_next_addr = '0; m_due = 0; m_due_word = '0;
    end else begin
      new_due = 0;
      if (m_remaining > 0) begin
        if (!in_win(m_next_addr)) begin
          m_remaining = 0; new_due = 2;
        end else if (gnt) begin
          new_due = 1; m_due_word = m_next_addr[11:2];
          m_remaining--; m_next_addr += 32'd4;
        end
      end else if (e_ack && req) begin
        ntxn++;
        $display("txn %0d: %s addr=%h bl=%0d", ntxn, cmd ? "wr" : "rd", addr, bl);
        if (!cmd && in_win(addr)) begin
          new_due = 1; m_due_word = addr[11:2];
          m_remaining = (bl == 0) ? 0 : int'(bl) - 1;
          m_next_addr = addr + 32'd4;
        end else begin
          new_due = 2;
        end
      end
      m_due = new_due;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 3'd0, 1);
  endtask

  task automatic single_read_check();
    cycle(0, 1, 0, 32'h0001_0010, 3'd1, 1);
    chk("s1_ack", obs_ack, 1); chk("s1_cs", obs_cs, 1); chk("s1_maddr", obs_maddr, 4);
    idle(1);
    chk("s1_resp", obs_resp, 1); chk("s1_data", obs_rdata, 32'hDEAD_BEEF);
    idle(1);
    chk("s1_after", obs_resp, 0);
  endtask

  initial begin
    logic [31:0] dexp [4];
    logic [1:0]  r3 [5];
    logic [31:0] d3 [5];
    logic [31:0] a;
    dexp = '{D0, D1, D2, D3};
    r3   = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
    d3   = '{D0, 32'h0, D1, D2, D3};
    for (int i = 0; i < 1024; i++) sram[i] = $urandom;
    sram[0] = D0; sram[1] = D1; sram[2] = D2; sram[3] = D3;
    sram[4] = 32'hDEAD_BEEF; sram[1022] = E0; sram[1023] = E1;
    m_remaining = 0; m_next_addr = '0; m_due = 0; m_due_word = '0;
    rst = 1; imem_req = 0; imem_cmd = 0; imem_addr = '0; imem_bl = '0; mem_gnt = 1;

    // Reset: ack forced low even with a request and grant present.
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, 0, 32'h0001_0000, 3'd1, 1);
      chk("rst_ack", obs_ack, 0); chk("rst_resp", obs_resp, 0); chk("rst_cs", obs_cs, 0);
    end
    idle(1);
    chk("post_rst_resp", obs_resp, 0);

    single_read_check();

    // Four-beat burst, grant held.
    cycle(0, 1, 0, 32'h0001_0000, 3'd4, 1);
    chk("s2_maddr0", obs_maddr, 0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("s2_resp", obs_resp, 1); chk("s2_data", obs_rdata, dexp[k]);
      chk("s2_ack", obs_ack, (k == 3) ? 1 : 0);
      if (k < 3) chk("s2_maddr", obs_maddr, k + 1);
    end
    idle(1);
    chk("s2_end", obs_resp, 0);

    // Same burst with one grant gap.
    cycle(0, 1, 0, 32'h0001_0000, 3'd4, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 32'h0, 3'd0, (k == 0) ? 1'b0 : 1'b1);
      chk("s3_resp", obs_resp, r3[k]); chk("s3_data", obs_rdata, d3[k]);
    end
    idle(1);

    // Write, then out-of-window read: both answered with a single error cycle.
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 32'h0001_0000 : 32'h0002_0000;
      cycle(0, 1, (k == 0), a, 3'd1, 1);
      chk("s4_ack", obs_ack, 1); chk("s4_cs", obs_cs, 0);
      idle(1);
      chk("s4_resp", obs_resp, 2); chk("s4_ack_err", obs_ack, 0);
      idle(1);
      chk("s4_after", obs_resp, 0); chk("s4_ack_again", obs_ack, 1);
    end

    // Burst that walks off the end of the window.
    cycle(0, 1, 0, 32'h0001_0FF8, 3'd4, 1);
    chk("s5_maddr", obs_maddr, 10'h3FE);
    idle(1);
    chk("s5_r0", obs_resp, 1); chk("s5_d0", obs_rdata, E0); chk("s5_maddr1", obs_maddr, 10'h3FF);
    idle(1);
    chk("s5_r1", obs_resp, 1); chk("s5_d1", obs_rdata, E1); chk("s5_cs_miss", obs_cs, 0);
    idle(1);
    chk("s5_err", obs_resp, 2);
    idle(1);
    chk("s5_idle", obs_resp, 0);

    // Back-to-back singles, then reset in the middle of a burst.
    cycle(0, 1, 0, 32'h0001_0000, 3'd1, 1);
    cycle(0, 1, 0, 32'h0001_0004, 3'd1, 1);
    chk("s6_r0", obs_resp, 1); chk("s6_d0", obs_rdata, D0);
    chk("s6_ack", obs_ack, 1); chk("s6_maddr", obs_maddr, 1);
    idle(1);
    chk("s6_r1", obs_resp, 1); chk("s6_d1", obs_rdata, D1);
    cycle(0, 1, 0, 32'h0001_0000, 3'd4, 1);
    idle(1);
    cycle(1, 1, 0, 32'h0001_0000, 3'd1, 1);
    chk("s6_rst_ack", obs_ack, 0); chk("s6_rst_resp", obs_resp, 0);
    idle(1);
    chk("s6_discard", obs_resp, 0);
    single_read_check();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h0002_0000 + $urandom_range(0, 255);
        1, 2:    a = 32'h0001_0FE0 + $urandom_range(0, 31);
        default: a = 32'h0001_0000 + $urandom_range(0, 4095);
      endcase
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
            a, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 8);
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
